// File: rtl/alu_seq_unit.sv
// Registered accumulator ALU with start/done handshake, Z/N/C flags and
// multi-cycle serial shifts and shift-add multiply.
module alu_seq_unit #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] BusOut,
  input  logic             Load_AC,
  output logic [WIDTH-1:0] AC,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               shift_left;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     inc_sum;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   step_res;
  logic               step_out;
  logic [2*WIDTH-1:0] mul_sum;

  always_comb begin
    add_sum  = {1'b0, AC} + {1'b0, BusOut};
    sub_diff = {1'b0, AC} - {1'b0, BusOut};
    inc_sum  = {1'b0, AC} + (WIDTH+1)'(1);
    shamt    = BusOut[SHW-1:0];
    // Shifts by zero fall through here: AC unchanged, C cleared.
    sc_res   = AC;
    sc_c     = 1'b0;
    case (ALU_OP)
      OP_PASS: sc_res = BusOut;
      OP_ADD:  {sc_c, sc_res} = add_sum;
      OP_SUB:  {sc_c, sc_res} = sub_diff;
      OP_AND:  sc_res = AC & BusOut;
      OP_OR:   sc_res = AC | BusOut;
      OP_XOR:  sc_res = AC ^ BusOut;
      OP_NOT:  sc_res = ~AC;
      OP_INC:  {sc_c, sc_res} = inc_sum;
      default: ;
    endcase

    if (shift_left) begin
      step_res = {work[WIDTH-2:0], 1'b0};
      step_out = work[WIDTH-1];
    end else begin
      step_res = {1'b0, work[WIDTH-1:1]};
      step_out = work[0];
    end

    mul_sum = prod + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      AC         <= '0;
      Z          <= 1'b0;
      N          <= 1'b0;
      C          <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      cnt        <= '0;
      shift_left <= 1'b0;
      work       <= '0;
      mplier     <= '0;
      mcand      <= '0;
      prod       <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (ALU_OP > OP_MUL) begin
              Done <= 1'b1;
            end else if (ALU_OP == OP_MUL) begin
              state  <= MUL;
              Busy   <= 1'b1;
              cnt    <= CW'(WIDTH);
              mcand  <= {{WIDTH{1'b0}}, AC};
              mplier <= BusOut;
              prod   <= '0;
            end else if ((ALU_OP == OP_SHL || ALU_OP == OP_SHR) && shamt != '0) begin
              state      <= SHIFT;
              Busy       <= 1'b1;
              cnt        <= {1'b0, shamt};
              shift_left <= (ALU_OP == OP_SHL);
              work       <= AC;
            end else begin
              AC   <= sc_res;
              C    <= sc_c;
              Z    <= (sc_res == '0);
              N    <= sc_res[WIDTH-1];
              Done <= 1'b1;
            end
          end else if (Load_AC) begin
            AC <= BusOut;
          end
        end

        SHIFT: begin
          // The final step commits straight from the combinational shifter.
          if (cnt == CW'(1)) begin
            AC    <= step_res;
            C     <= step_out;
            Z     <= (step_res == '0);
            N     <= step_res[WIDTH-1];
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= IDLE;
          end else begin
            work <= step_res;
          end
          cnt <= cnt - CW'(1);
        end

        MUL: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          prod   <= mul_sum;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            AC    <= mul_sum[WIDTH-1:0];
            C     <= |mul_sum[2*WIDTH-1:WIDTH];
            Z     <= (mul_sum[WIDTH-1:0] == '0);
            N     <= mul_sum[WIDTH-1];
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: expected results queued at issue time,
// popped and compared when Done is observed.
module tb_alu_seq_unit;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start;
  logic [3:0] ALU_OP;
  logic [7:0] BusOut;
  logic       Load_AC;
  logic [7:0] AC;
  logic       Z, N, C, Busy, Done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] ac;
    logic       z;
    logic       n;
    logic       c;
    int         busy;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_ac;
  logic       m_z, m_n, m_c;

  alu_seq_unit #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .ALU_OP(ALU_OP),
    .BusOut(BusOut), .Load_AC(Load_AC), .AC(AC),
    .Z(Z), .N(N), .C(C), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] val);
    Load_AC = 1'b1;
    BusOut  = val;
    @(negedge Clk);
    Load_AC = 1'b0;
    BusOut  = 8'h00;
    m_ac    = val;
    check("load_ac", AC, val);
    check("load_done", Done, 1'b0);
    check("load_flags", {Z, N, C}, {m_z, m_n, m_c});
    $display("load   ac=%02h z=%0b n=%0b c=%0b", AC, Z, N, C);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] bus,
                       input logic [7:0] eac, input logic ez, input logic en,
                       input logic ec, input int ebusy, input bit poke);
    exp_t e;
    int   nb;
    sb.push_back('{tag, eac, ez, en, ec, ebusy});
    Start  = 1'b1;
    ALU_OP = op;
    BusOut = bus;
    @(negedge Clk);
    Start  = 1'b0;
    ALU_OP = 4'd6;
    BusOut = 8'hFF;
    nb = 0;
    while (Done !== 1'b1 && nb < 40) begin
      check({tag, "_busy"}, Busy, 1'b1);
      check({tag, "_hold"}, AC, m_ac);
      if (poke) begin
        Start   = 1'b1;
        Load_AC = 1'b1;
        ALU_OP  = 4'd0;
      end
      nb++;
      @(negedge Clk);
    end
    Start   = 1'b0;
    Load_AC = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done"}, Done, 1'b1);
    check({e.tag, "_busy_end"}, Busy, 1'b0);
    check({e.tag, "_busy_cycles"}, 16'(nb), 16'(e.busy));
    check({e.tag, "_ac"}, AC, e.ac);
    check({e.tag, "_flags"}, {Z, N, C}, {e.z, e.n, e.c});
    m_ac = e.ac;
    m_z  = e.z;
    m_n  = e.n;
    m_c  = e.c;
    $display("op %-6s code=%0d bus=%02h ac=%02h z=%0b n=%0b c=%0b busy_cycles=%0d",
             e.tag, op, bus, AC, Z, N, C, nb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    Rst_n   = 1'b0;
    Start   = 1'b1;
    ALU_OP  = 4'd1;
    BusOut  = 8'h33;
    Load_AC = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_ac", AC, 8'h00);
    check("rst_flags", {Z, N, C}, 3'b000);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    $display("reset  ac=%02h z=%0b n=%0b c=%0b busy=%0b done=%0b", AC, Z, N, C, Busy, Done);
    m_ac = 8'h00; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    Rst_n = 1'b1;
    Start = 1'b0;

    load(8'h15);
    do_op("add1", 4'd1, 8'hAA, 8'hBF, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_op("add2", 4'd1, 8'h41, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    load(8'h15);
    do_op("sub", 4'd2, 8'hAA, 8'h6B, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    do_op("rsvd", 4'd12, 8'h99, 8'h6B, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    load(8'h15);
    do_op("shr3", 4'd9, 8'hF3, 8'h02, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    do_op("shl0", 4'd8, 8'h08, 8'h02, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    load(8'h15);
    do_op("mul1", 4'd10, 8'h0C, 8'hFC, 1'b0, 1'b1, 1'b0, 8, 1'b0);
    load(8'h15);
    do_op("mul2", 4'd10, 8'hAA, 8'hF2, 1'b0, 1'b1, 1'b1, 8, 1'b1);
    do_op("xor", 4'd5, 8'hFF, 8'h0D, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_op("not", 4'd6, 8'h00, 8'hF2, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    load(8'hFF);
    do_op("inc", 4'd7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    do_op("or", 4'd4, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_op("and", 4'd3, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    do_op("pass", 4'd0, 8'h81, 8'h81, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    do_op("shl1", 4'd8, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    load(8'h03);
    do_op("shl7", 4'd8, 8'h07, 8'h80, 1'b0, 1'b1, 1'b1, 7, 1'b0);

    // Reset in the middle of a multiply aborts it without a Done pulse.
    load(8'h15);
    Start  = 1'b1;
    ALU_OP = 4'd10;
    BusOut = 8'hAA;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    check("abort_ac", AC, 8'h00);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_flags", {Z, N, C}, 3'b000);
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge Clk);
      if (Done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 1'b0);
    check("abort_ac_after", AC, 8'h00);
    $display("abort  ac=%02h busy=%0b done_seen=%0b", AC, Busy, seen_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered accumulator ALU that keeps AC inside the block. It adds a start/done handshake, Z/N/C flags and multi-cycle ops (barrel-free shifts, shift-add multiply) to the combinational 8-bit AC/BusOut ALU. It sits between the internal bus (BusOut) and the control unit, which issues Start/ALU_OP and waits for Done before the next micro-step.

## Interface
- WIDTH, 8, datapath width; power of two, ≥4.
- SHW, $clog2(WIDTH) (derived, not overridable), width of shift-amount field.

- Clk  input  1  system clock; all state changes on rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Start  input  1  op request, sampled only in IDLE.
- ALU_OP  input  4  operation code, sampled with Start.
- BusOut  input  WIDTH  second operand, or shift amount (BusOut[SHW-1:0]), or load value.
- Load_AC  input  1  AC <= BusOut when IDLE and Start=0; flags unchanged.
- AC  output  WIDTH  accumulator.
- Z, N, C  output  1 each  zero, negative (MSB), carry/borrow/shift-out.
- Busy  output  1  multi-cycle op in progress.
- Done  output  1  one-cycle pulse: result valid in AC/flags.

## Operation
- Opcodes (result R → AC):
  - 0 PASS R=BusOut.
  - 1 ADD R=AC+BusOut, C=carry-out.
  - 2 SUB R=AC−BusOut, C=borrow (AC<BusOut unsigned).
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOT AC.
  - 7 INC AC, C=carry-out.
  - 8 SHL by n=BusOut[SHW-1:0], logical, C=last bit shifted out.
  - 9 SHR by n, logical, C=last bit shifted out.
  - 10 MUL unsigned AC×BusOut, R=low WIDTH bits, C=|(high WIDTH bits).
  - 11–15 reserved: AC/flags unchanged, Done still pulses.
- C handling: ops 3–6 and PASS clear C.
- Z/N: updated from R on every completed non-reserved op.
- All arithmetic is modulo 2^WIDTH; no signed overflow flag.
- FSM states:
  - IDLE → IDLE for single-cycle ops, shifts with n=0, and reserved ops.
  - IDLE → SHIFT for op 8/9 with n>0; counter = n.
  - IDLE → MUL for op 10; counter = WIDTH, multiplier latched from BusOut, multiplicand from AC, product register cleared.
  - SHIFT: one bit per cycle; → IDLE when counter reaches 0.
  - MUL: one shift-add step per cycle; → IDLE after WIDTH steps.
- AC updates only on completion; it holds its pre-op value while Busy.
- Priority in IDLE: Start > Load_AC. While Busy, Start, Load_AC, ALU_OP and BusOut are ignored (operands are latched).

## Timing
- Reset (Rst_n=0 at an edge): AC=0, Z=N=C=0, Busy=0, Done=0, state IDLE. Overrides everything, including mid-op: the op is aborted and no Done is issued.
- Single-cycle op, Start at edge k: AC/flags valid after edge k; Done=1 for the cycle after edge k; Busy stays 0.
- Shift by n>0, Start at edge k: Busy=1 after edges k..k+n−1; result and Done after edge k+n, with Busy=0 in that same cycle.
- MUL, Start at edge k: result and Done after edge k+WIDTH; Busy=1 for WIDTH cycles.
- Done never overlaps Busy. Start in the Done cycle is accepted, so back-to-back ops are allowed.
- Load_AC takes effect after the edge; no Done pulse.

## Test plan
- Reset with Start=1, ALU_OP=1 held, Rst_n=0 for 2 edges → AC=0x00, Z=N=C=0, Busy=0, Done=0.
- Load_AC BusOut=0x15, then ADD BusOut=0xAA → AC=0xBF, N=1, Z=0, C=0, Done one cycle after Start. Then ADD 0x41 → AC=0x00, Z=1, C=1.
- AC=0x15, SUB 0xAA → AC=0x6B, C=1. Then reserved op 0xC → AC=0x6B unchanged, Done pulses.
- AC=0x15, SHR n=3 → Busy 3 cycles, AC=0x02, C=1, Done at edge k+3. SHL n=0 → single-cycle, AC unchanged, C=0.
- AC=0x15, MUL 0x0C → AC=0xFC, C=0 at edge k+8. MUL with AC=0x15, BusOut=0xAA → AC=0xF2, C=1. Start/Load_AC pulsed while Busy have no effect.
- AC=0x15, MUL 0xAA, Rst_n=0 at edge k+4 → AC=0x00, Busy=0, no Done pulse afterwards.
